// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the UART transmitter.
// Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered, 16x oversampled, LSB first.
// The serial line is registered from the next-state decode.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST  = 3'(DBIT - 1);

  tx_state_t   state;
  tx_state_t   state_next;
  logic [SW-1:0] s;
  logic [SW-1:0] s_next;
  logic [2:0]  n;
  logic [2:0]  n_next;
  logic [7:0]  b;
  logic [7:0]  b_next;
  logic        tx_next;
  logic        done_next;
  logic        pop;
  logic        full;
  logic        empty;
  logic [7:0]  head;

  assign tx_ready = reset_n && !full;
  assign tx_busy  = state != IDLE;

  uart_tx_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (tx_valid && tx_ready),
    .pop    (pop),
    .din    (tx_data),
    .dout   (head),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      s       <= '0;
      n       <= '0;
      b       <= '0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_next;
      s       <= s_next;
      n       <= n_next;
      b       <= b_next;
      tx      <= tx_next;
      tx_done <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    pop        = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          b_next     = head;
          s_next     = '0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_LAST) begin
            s_next = '0;
            b_next = b >> 1;
            if (n == N_LAST)
              state_next = STOP;
            else
              n_next = n + 1'b1;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == SB_LAST) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level follows the state being entered, so tx lands with it.
  always_comb begin
    tx_next = 1'b1;
    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx.
// Frames are decoded from the line by mid-bit sampling.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data2 = '0;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready, tx, tx_busy, tx_done;
  logic       tx_ready2, tx2, tx_busy2, tx_done2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cnt2 = 0;
  bit tick_en = 1'b0;
  int tick_div = 0;

  always #5 clk = ~clk;

  uart_tx u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_tick  (s_tick),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  uart_tx #(.SB_TICK(32)) u_dut32 (
    .clk     (clk),
    .reset_n (reset_n),
    .s_tick  (s_tick),
    .tx_data (tx_data2),
    .tx_valid(tx_valid2),
    .tx_ready(tx_ready2),
    .tx      (tx2),
    .tx_busy (tx_busy2),
    .tx_done (tx_done2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    if (tx_done) done_cnt++;
    if (tx_done2) done_cnt2++;
    if (tick_en) begin
      tick_div = (tick_div + 1) % 16;
      s_tick = (tick_div == 0);
    end else begin
      tick_div = 0;
      s_tick = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return tx;
      1:       return tx_done;
      2:       return tx2;
      default: return tx_done2;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int w, input logic v,
                          input int budget, output int t);
    bit found = 1'b0;
    t = cyc;
    for (int i = 0; i < budget && !found; i++) begin
      if (sig(w) === v) begin
        found = 1'b1;
        t = cyc;
      end else begin
        step();
      end
    end
    chk(tag, found, 1);
  endtask

  task automatic push1(input logic [7:0] d);
    chk("push_ready", tx_ready, 1);
    tx_data = d;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic rx_frame(input string tag, output logic [7:0] d,
                          output int t0);
    wait_sig({tag, "_start"}, 0, 1'b0, 4000, t0);
    repeat (128) step();
    chk({tag, "_startbit"}, tx, 0);
    for (int k = 0; k < 8; k++) begin
      repeat (256) step();
      d[k] = tx;
    end
    repeat (256) step();
    chk({tag, "_stopbit"}, tx, 1);
  endtask

  logic [7:0] d;
  int t[10];
  int td, t0, d0, lows;
  logic [7:0] v3[3];
  logic [7:0] v6[6];

  initial begin
    // reset
    repeat (3) step();
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_ready", tx_ready, 0);
    reset_n = 1'b1;
    step();
    chk("rel_ready", tx_ready, 1);
    chk("rel_tx", tx, 1);

    // 0x55 frame timing and latency
    tick_en = 1'b1;
    d0 = done_cnt;
    push1(8'h55);
    chk("lat_k", tx, 1);
    step();
    chk("lat_k1", tx, 0);
    chk("busy_frame", tx_busy, 1);
    t[0] = cyc;
    for (int i = 1; i < 10; i++)
      wait_sig($sformatf("s55_lvl%0d", i), 0, logic'(i % 2), 400, t[i]);
    chk("s55_start_len", (t[1] - t[0]) >= 241 && (t[1] - t[0]) <= 256, 1);
    for (int i = 1; i < 9; i++)
      chk($sformatf("s55_bit%0d", i - 1), t[i+1] - t[i], 256);
    wait_sig("s55_done", 1, 1'b1, 400, td);
    chk("s55_stop_len", td - t[9], 256);
    repeat (5) step();
    chk("s55_done_cnt", done_cnt - d0, 1);
    chk("s55_idle", tx_busy, 0);

    // back-to-back frames
    v3[0] = 8'hA5; v3[1] = 8'h3C; v3[2] = 8'hFF;
    d0 = done_cnt;
    for (int j = 0; j < 3; j++) push1(v3[j]);
    for (int j = 0; j < 3; j++) begin
      rx_frame($sformatf("b2b%0d", j), d, t0);
      chk($sformatf("b2b%0d_data", j), d, v3[j]);
      if (j > 0) chk($sformatf("b2b%0d_gap", j), t0 - td, 1);
      wait_sig($sformatf("b2b%0d_done", j), 1, 1'b1, 400, td);
    end
    repeat (300) step();
    chk("b2b_done_cnt", done_cnt - d0, 3);
    chk("b2b_empty_busy", tx_busy, 0);
    chk("b2b_empty_tx", tx, 1);

    // fill while ticks are stalled
    tick_en = 1'b0;
    step();
    v6[0] = 8'h11; v6[1] = 8'h22; v6[2] = 8'h33;
    v6[3] = 8'h44; v6[4] = 8'h55; v6[5] = 8'h66;
    for (int i = 0; i < 6; i++) begin
      tx_data = v6[i];
      tx_valid = 1'b1;
      chk($sformatf("fill_ready%0d", i), tx_ready, i < 5);
      step();
    end
    tx_valid = 1'b0;
    repeat (50) step();
    chk("stall_tx", tx, 0);
    chk("stall_busy", tx_busy, 1);
    chk("stall_full", tx_ready, 0);
    d0 = done_cnt;
    tick_en = 1'b1;
    for (int j = 0; j < 5; j++) begin
      rx_frame($sformatf("fill%0d", j), d, t0);
      chk($sformatf("fill%0d_data", j), d, v6[j]);
      wait_sig($sformatf("fill%0d_done", j), 1, 1'b1, 400, td);
    end
    repeat (400) step();
    chk("fill_done_cnt", done_cnt - d0, 5);
    chk("fill_idle", tx_busy, 0);

    // loopback patterns
    v3[0] = 8'h00; v3[1] = 8'hFF; v3[2] = 8'h81;
    for (int j = 0; j < 3; j++) begin
      d0 = done_cnt;
      push1(v3[j]);
      rx_frame($sformatf("lb%0d", j), d, t0);
      chk($sformatf("lb%0d_data", j), d, v3[j]);
      wait_sig($sformatf("lb%0d_done", j), 1, 1'b1, 400, td);
      step();
      chk($sformatf("lb%0d_done_cnt", j), done_cnt - d0, 1);
    end

    // reset during data bit 3 of 0x0F with a byte queued
    push1(8'h0F);
    push1(8'h99);
    wait_sig("mrst_start", 0, 1'b0, 400, t0);
    repeat (128 + 256 * 4) step();
    chk("mrst_bit3", tx, 1);
    chk("mrst_busy_pre", tx_busy, 1);
    d0 = done_cnt;
    reset_n = 1'b0;
    step();
    chk("mrst_tx", tx, 1);
    chk("mrst_busy", tx_busy, 0);
    chk("mrst_done", tx_done, 0);
    chk("mrst_ready", tx_ready, 0);
    reset_n = 1'b1;
    step();
    chk("mrst_rel_ready", tx_ready, 1);
    lows = 0;
    repeat (600) begin
      step();
      if (!tx || tx_busy) lows++;
    end
    chk("mrst_fifo_empty", lows, 0);
    chk("mrst_no_done", done_cnt - d0, 0);

    // two stop bits on the SB_TICK=32 instance
    d0 = done_cnt2;
    tx_data2 = 8'h00;
    tx_valid2 = 1'b1;
    step();
    tx_valid2 = 1'b0;
    wait_sig("sb32_start", 2, 1'b0, 400, t[0]);
    wait_sig("sb32_stop", 2, 1'b1, 4000, t[1]);
    chk("sb32_frame_len",
        (t[1] - t[0]) >= 2289 && (t[1] - t[0]) <= 2304, 1);
    wait_sig("sb32_done", 3, 1'b1, 1000, td);
    chk("sb32_stop_len", td - t[1], 512);
    step();
    chk("sb32_done_cnt", done_cnt2 - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame (5..8).
REQ-002 Parameter SB_TICK, default 16, stop-bit length in s_tick units (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 Parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, >= 2).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 s_tick  input  1  16x-oversampling baud tick, one clk wide.
REQ-007 tx_data  input  8  byte to send; bits [DBIT-1:0] used.
REQ-008 tx_valid  input  1  tx_data valid.
REQ-009 tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-010 tx  output  1  UART serial line, idle high, registered.
REQ-011 tx_busy  output  1  high while a frame is in progress (state != IDLE).
REQ-012 tx_done  output  1  one-cycle pulse at end of stop bit.

Function
REQ-013 Byte SHALL be accepted into the FIFO on any rising edge where tx_valid && tx_ready; tx_data unchanged otherwise.
REQ-014 tx_ready SHALL equal !fifo_full; tx_valid while full is ignored, no overwrite.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP; 4-bit tick counter s, 3-bit bit counter n, 8-bit shift register b.
REQ-016 IDLE: tx=1; if FIFO non-empty, pop head into b, s=0, go to START, tx driven 0 from the next edge.
REQ-017 START: tx=0; on s_tick, if s==15 go to DATA with s=0, n=0, else s+1.
REQ-018 DATA: tx=b[0]; on s_tick, if s==15 then s=0, b shifted right one (LSB first), and if n==DBIT-1 go to STOP else n+1; else s+1.
REQ-019 STOP: tx=1; on s_tick, if s==SB_TICK-1 pulse tx_done, go to IDLE; else s+1 (counter width sized for SB_TICK).
REQ-020 Counters SHALL advance only on cycles with s_tick high; with s_tick held low all state, tx and counters hold.
REQ-021 Latency: byte accepted at edge k with FIFO empty and FSM in IDLE -> tx=0 from edge k+1.
REQ-022 Back-to-back: queued byte SHALL be popped in the single IDLE cycle following tx_done; gap between frames is exactly one clk.
REQ-023 Push and pop in the same cycle SHALL both take effect; count unchanged; pop never from an empty FIFO.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty from a count of width clog2(FIFO_DEPTH)+1.
REQ-025 tx_busy SHALL be high from the edge entering START through the edge returning to IDLE.

Reset
REQ-026 While reset_n low at a clk edge: state=IDLE, s=n=0, b=0, FIFO emptied, tx=1, tx_done=0, tx_busy=0.
REQ-027 tx_ready SHALL be forced low while reset_n is low and equal !fifo_full from the first cycle after release.
REQ-028 Reset mid-frame SHALL abort the frame, drop FIFO contents, and return tx high on the next edge; no tx_done pulse.

Structure
REQ-029 State enum tx_state_t (IDLE, START, DATA, STOP) and OVERSAMPLE=16 SHALL live in shared package uart_pkg, also used by uart_rx.
REQ-030 FIFO SHALL be a separate sub-module uart_tx_fifo (parameters WIDTH=8, DEPTH; ports push, pop, din, dout, full, empty).
REQ-031 tx SHALL come from a flop, with no combinational path from inputs to tx.

Verification
REQ-032 Send 0x55, DBIT=8, s_tick every 16 clk: tx = 0,1,0,1,0,1,0,1,0,1 with each bit 256 clk, then stop 256 clk; one tx_done.
REQ-033 Push 0xA5, 0x3C, 0xFF consecutively: three frames, one-clk idle gap each, three tx_done pulses, FIFO empty at end.
REQ-034 s_tick held low, push 6 bytes: 5 accepted (1 in shift reg, 4 in FIFO), tx_ready low at 6th; resume ticks -> 5 frames in order.
REQ-035 Assert reset_n low during DATA bit 3 of 0x0F: tx=1 next edge, tx_busy=0, FIFO empty, no tx_done.
REQ-036 SB_TICK=32, send 0x00: stop phase lasts 32 ticks (512 clk) before tx_done.
REQ-037 Loopback with uart_rx sharing s_tick: bytes 0x00, 0xFF, 0x81 received intact with rx_done per byte.
